// File: rtl/audio_codec_link.sv
// audio_codec_link: I2S master framing for a slave-mode codec.
// Generates BCLK/LRCK and serializes one 16-bit sample per frame onto both DAC
// channels. Deserializes the left ADC channel and hands the word to the sample
// generator with a sample_req / sample_end handshake.
module audio_codec_link #(
  parameter int BCLK_DIV = 4  // clk cycles per aud_bclk half-period, >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] dac_data,
  output logic [15:0] adc_data,
  output logic        sample_req,
  output logic        sample_end,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_adclrck,
  output logic        aud_dacdat,
  input  logic        aud_adcdat
);

  localparam int DIV_W = $clog2(BCLK_DIV);

  logic [DIV_W-1:0] div;       // half-period divider
  logic [4:0]       k;         // BCLK slot within the frame, 0..31
  logic [4:0]       k_next;
  logic [15:0]      tx_shift;  // DAC serializer, MSB is on the wire
  logic [15:0]      dac_hold;  // sample kept for the right channel
  logic [15:0]      rx_shift;  // left ADC deserializer
  logic             tick;      // divider terminal count
  logic             rise;      // aud_bclk goes 0->1 on this edge
  logic             fall;      // aud_bclk goes 1->0 on this edge
  logic             rx_win;    // slot carries a left-channel ADC bit

  assign tick   = (div == DIV_W'(BCLK_DIV - 1));
  assign rise   = tick & ~aud_bclk;
  assign fall   = tick &  aud_bclk;
  assign k_next = k + 5'd1;
  assign rx_win = (k != 5'd0) && (k <= 5'd16);

  assign aud_adclrck = aud_daclrck;
  assign aud_dacdat  = tx_shift[15];

  // Bit-clock divider: toggle aud_bclk every BCLK_DIV clk cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      aud_bclk <= 1'b0;
    end else if (tick) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of its peers, exactly like flip-flops do.
      div      <= '0;
      aud_bclk <= ~aud_bclk;
    end else begin
      div      <= div + DIV_W'(1);
    end
  end

  // Slot counter, word select and frame-start request, all advanced on falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= 5'd31;
      aud_daclrck <= 1'b0;
      sample_req  <= 1'b0;
    end else begin
      sample_req <= 1'b0;
      if (fall) begin
        k           <= k_next;
        aud_daclrck <= k_next[4];
        sample_req  <= (k_next == 5'd0);
      end
    end
  end

  // DAC serializer: load the fresh sample for the left word, replay it for the
  // right word, otherwise shift MSB-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
      dac_hold <= '0;
    end else if (fall) begin
      if (k_next == 5'd1) begin
        dac_hold <= dac_data;
        tx_shift <= dac_data;
      end else if (k_next == 5'd17) begin
        tx_shift <= dac_hold;
      end else begin
        tx_shift <= {tx_shift[14:0], 1'b0};
      end
    end
  end

  // ADC deserializer: sample left-channel bits on rises; publish after the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift   <= '0;
      adc_data   <= '0;
      sample_end <= 1'b0;
    end else begin
      sample_end <= 1'b0;
      if (rise && rx_win) begin
        rx_shift <= {rx_shift[14:0], aud_adcdat};
        if (k == 5'd16) begin
          adc_data   <= {rx_shift[14:0], aud_adcdat};
          sample_end <= 1'b1;
        end
      end
    end
  end

endmodule
